udp_rx_unload: RTL and testbench
================================

UDP_RX_UNLOAD -- requirements
Module: udp_rx_unload

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-002 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port udp_rec_data_valid, input, 1: one-cycle pulse meaning a checked UDP datagram is in the receive RAM.
REQ-004 SHALL have port udp_rec_data_length, input, 16: UDP length field (8-byte header plus payload), stable from the pulse until the next pulse.
REQ-005 SHALL have port udp_rec_ram_read_addr, output, 11: byte address into the receive RAM (payload byte 0 at address 0).
REQ-006 SHALL have port udp_rec_ram_rdata, input, 8: RAM read data, valid exactly one cycle after the address is presented.
REQ-007 SHALL have ports m_tdata (output, 8), m_tvalid (output, 1), m_tready (input, 1) and m_tlast (output, 1): payload byte stream.
REQ-008 SHALL have port busy, output, 1: high from acceptance of a datagram until its last byte is transferred.
REQ-009 SHALL have ports frame_cnt (output, 16) and drop_cnt (output, 16): statistics counters.

Function
REQ-010 SHALL compute payload length as udp_rec_data_length minus 8.
REQ-011 SHALL accept a pulse only when the payload length is between 1 and 2048 inclusive.
REQ-012 SHALL drop a pulse whose payload length is outside 1..2048: no bytes are output and drop_cnt increments by 1.
REQ-013 SHALL implement the FSM states IDLE, READ and DRAIN; reset state is IDLE.
REQ-014 IDLE -> READ on an accepted pulse: latch the length, set the read address to 0, assert busy on the next cycle.
REQ-015 READ: issue one RAM read per cycle while the internal 2-entry output FIFO has room for the byte still in flight.
  - Increment the address after each read.
  - Go to DRAIN after issuing address length-1.
REQ-016 DRAIN -> IDLE in the cycle after the byte flagged m_tlast transfers (m_tvalid and m_tready both high); frame_cnt increments on that transfer.
REQ-017 Handshake rules:
  - A byte SHALL transfer only when m_tvalid and m_tready are high in the same cycle.
  - Once m_tvalid is asserted, m_tvalid and m_tdata SHALL hold until transfer.
  - m_tlast SHALL be high only with the final payload byte.
REQ-018 Latency: pulse in cycle N with m_tready held high gives the first m_tvalid in cycle N+3, then one byte per cycle with no bubbles.
REQ-019 Backpressure: with m_tready low, no byte SHALL be lost or duplicated; the FIFO absorbs the one-cycle RAM latency.
REQ-020 A pulse arriving while busy SHALL be ignored: the current transfer continues unaffected and drop_cnt increments.
REQ-021 Payload length 1: the single byte SHALL carry m_tlast.
REQ-022 Payload length 2048: addresses 0..2047 SHALL be read with no address wrap.
REQ-023 Counters SHALL saturate at 16'hFFFF.

Reset
REQ-024 While rst is high:
  - FSM goes to IDLE and the FIFO empties.
  - udp_rec_ram_read_addr=0, m_tdata=0, m_tvalid=0, m_tlast=0, busy=0, frame_cnt=0, drop_cnt=0.
REQ-025 Reset asserted mid-datagram SHALL abort it with no m_tlast issued; the first pulse after reset deasserts is handled normally.

Configuration
REQ-026 Macro UDP_RX_UNLOAD_STATS_EN compiles the statistics in or out.
  - Defined: frame_cnt and drop_cnt behave per REQ-012, REQ-016, REQ-020 and REQ-023.
  - Undefined: both outputs are tied to constant 0, no counter registers exist, and all other behaviour is identical.

Structure
REQ-027 A shared package SHALL hold:
  - the FSM state encoding;
  - UDP_HDR_LEN=8, UDP_RAM_AW=11 and UDP_MAX_PAYLOAD=2048.
REQ-028 The 2-entry output FIFO SHALL be a sub-module named udp_rx_unload_fifo; all other logic is flat.

Verification
REQ-029 Length 8+4 with RAM holding A0 A1 A2 A3 and m_tready=1 -> bytes A0..A3 in cycles N+3..N+6, m_tlast on A3, frame_cnt=1.
REQ-030 Length 8+16 with m_tready toggling 1010... -> all 16 bytes in order, none duplicated or missing, m_tlast only on byte 15.
REQ-031 Lengths 8, 7 and 8+2049 -> no m_tvalid, drop_cnt=3.
REQ-032 Second pulse 5 cycles into a 100-byte datagram -> the first datagram completes intact, drop_cnt=1, frame_cnt=1.
REQ-033 rst high for 1 cycle at byte 50 of 100 -> all outputs 0 per REQ-024; a following 3-byte datagram is output correctly.
REQ-034 Length 8+2048 -> last read address 2047, 2048 bytes output, busy low afterwards; with the macro undefined, counters read 0 throughout.

Source files
------------

// File: rtl/udp_rx_unload_pkg.sv
// Shared FSM encoding and sizing constants for the UDP receive-RAM unloader.
package udp_rx_unload_pkg;

    localparam int unsigned UDP_HDR_LEN     = 8;
    localparam int unsigned UDP_RAM_AW      = 11;
    localparam int unsigned UDP_MAX_PAYLOAD = 2048;
    localparam int unsigned UDP_FIFO_W      = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/udp_rx_unload_fifo.sv
// Two-entry registered FIFO holding {last, data} between the RAM read port and the stream output.
module udp_rx_unload_fifo #(
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       cnt_q, cnt_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out_data  = mem_q[rd_ptr_q];
    assign out_valid = (cnt_q != '0);
    assign count     = cnt_q;

endmodule

// File: rtl/udp_rx_unload.sv
// Streams a checked UDP payload out of the receive RAM as a byte stream with backpressure.
// Define UDP_RX_UNLOAD_STATS_EN to build in the frame/drop statistics counters.
module udp_rx_unload
    import udp_rx_unload_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        udp_rec_data_valid,
    input  logic [15:0] udp_rec_data_length,
    output logic [10:0] udp_rec_ram_read_addr,
    input  logic [7:0]  udp_rec_ram_rdata,
    output logic [7:0]  m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic [15:0] drop_cnt
);

    state_e                state_q, state_d;
    logic [UDP_RAM_AW-1:0] addr_q, addr_d;
    logic [UDP_RAM_AW:0]   len_q, len_d;
    logic                  rd_vld_q, rd_vld_d;
    logic                  rd_last_q, rd_last_d;

    logic [15:0]           pay_len;
    logic                  pulse_ok;
    logic                  accept;
    logic                  pop;
    logic                  issue;
    logic                  is_last_addr;
    logic [2:0]            occ_next;
    logic [UDP_FIFO_W-1:0] fifo_dout;
    logic                  fifo_valid;
    logic [1:0]            fifo_count;

    assign pay_len  = udp_rec_data_length - 16'(UDP_HDR_LEN);
    assign pulse_ok = (pay_len != '0) && (pay_len <= 16'(UDP_MAX_PAYLOAD));
    assign accept   = udp_rec_data_valid && (state_q == ST_IDLE) && pulse_ok;
    assign pop      = fifo_valid && m_tready;

    // A read issued now lands in the FIFO next cycle, so count the byte in flight as occupied.
    assign occ_next     = {1'b0, fifo_count} + {2'b00, rd_vld_q} - {2'b00, pop};
    assign issue        = (state_q == ST_READ) && (occ_next <= 3'd1);
    assign is_last_addr = ({1'b0, addr_q} == (len_q - 1'b1));

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        rd_vld_d  = issue;
        rd_last_d = issue && is_last_addr;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_READ;
                    addr_d  = '0;
                    len_d   = pay_len[UDP_RAM_AW:0];
                end
            end
            ST_READ: begin
                if (issue) begin
                    if (is_last_addr) begin
                        state_d = ST_DRAIN;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && fifo_dout[8]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            rd_vld_q  <= rd_vld_d;
            rd_last_q <= rd_last_d;
        end
    end

    udp_rx_unload_fifo #(
        .WIDTH(UDP_FIFO_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rd_vld_q),
        .push_data({rd_last_q, udp_rec_ram_rdata}),
        .pop      (pop),
        .out_data (fifo_dout),
        .out_valid(fifo_valid),
        .count    (fifo_count)
    );

    assign udp_rec_ram_read_addr = addr_q;
    assign m_tdata               = fifo_dout[7:0];
    assign m_tvalid              = fifo_valid;
    assign m_tlast               = fifo_valid && fifo_dout[8];
    assign busy                  = (state_q != ST_IDLE);

`ifdef UDP_RX_UNLOAD_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic        drop;

    assign drop = udp_rec_data_valid && !accept;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (pop && fifo_dout[8] && (frame_cnt_q != 16'hFFFF)) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`else
    assign frame_cnt = '0;
    assign drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_udp_rx_unload.sv
// Directed self-checking bench for udp_rx_unload with a registered-read RAM model.
`timescale 1ns/1ps
module tb_udp_rx_unload;

`ifdef UDP_RX_UNLOAD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        udp_rec_data_valid;
    logic [15:0] udp_rec_data_length;
    logic [10:0] udp_rec_ram_read_addr;
    logic [7:0]  udp_rec_ram_rdata;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        busy;
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;

    udp_rx_unload dut (
        .clk                  (clk),
        .rst                  (rst),
        .udp_rec_data_valid   (udp_rec_data_valid),
        .udp_rec_data_length  (udp_rec_data_length),
        .udp_rec_ram_read_addr(udp_rec_ram_read_addr),
        .udp_rec_ram_rdata    (udp_rec_ram_rdata),
        .m_tdata              (m_tdata),
        .m_tvalid             (m_tvalid),
        .m_tready             (m_tready),
        .m_tlast              (m_tlast),
        .busy                 (busy),
        .frame_cnt            (frame_cnt),
        .drop_cnt             (drop_cnt)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [0:2047];
    always @(posedge clk) udp_rec_ram_rdata <= ram[udp_rec_ram_read_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] stat(input int v);
        return STATS ? 32'(v) : 32'd0;
    endfunction

    // Monitor: records transfers and checks the hold rule; clears its history during reset.
    logic [7:0] rx_data [$];
    logic       rx_last [$];
    int         rx_cyc  [$];
    int         tvalid_cnt = 0;
    int         max_addr = 0;
    logic       prev_v = 1'b0;
    logic       prev_r = 1'b0;
    logic [7:0] prev_d = '0;

    always @(negedge clk) begin
        if (rst) begin
            rx_data.delete();
            rx_last.delete();
            rx_cyc.delete();
            tvalid_cnt = 0;
            max_addr   = 0;
            prev_v     = 1'b0;
        end else begin
            if (prev_v && !prev_r) begin
                check("hold_tvalid", {31'd0, m_tvalid}, 32'd1);
                check("hold_tdata", {24'd0, m_tdata}, {24'd0, prev_d});
            end
            if (m_tvalid) tvalid_cnt++;
            if (m_tvalid && m_tready) begin
                rx_data.push_back(m_tdata);
                rx_last.push_back(m_tlast);
                rx_cyc.push_back(cyc);
            end
            if (int'(udp_rec_ram_read_addr) > max_addr) max_addr = int'(udp_rec_ram_read_addr);
            prev_v = m_tvalid;
            prev_r = m_tready;
            prev_d = m_tdata;
        end
    end

    int pulse_cyc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic send(input int len);
        udp_rec_data_length = 16'(len);
        udp_rec_data_valid  = 1'b1;
        pulse_cyc           = cyc;
        tick();
        udp_rec_data_valid  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int n, input bit toggle);
        int k = 0;
        while ((rx_data.size() < n || busy) && k < 6000) begin
            if (toggle) m_tready = ~m_tready;
            tick();
            k++;
        end
        m_tready = 1'b1;
        check(tag, {31'd0, k < 6000}, 32'd1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_addr"},  {21'd0, udp_rec_ram_read_addr}, 32'd0);
        check({tag, "_tdata"}, {24'd0, m_tdata}, 32'd0);
        check({tag, "_tvalid"}, {31'd0, m_tvalid}, 32'd0);
        check({tag, "_tlast"}, {31'd0, m_tlast}, 32'd0);
        check({tag, "_busy"},  {31'd0, busy}, 32'd0);
        check({tag, "_frame"}, {16'd0, frame_cnt}, 32'd0);
        check({tag, "_drop"},  {16'd0, drop_cnt}, 32'd0);
    endtask

    task automatic check_pattern(input string tag, input int n);
        int bad = 0;
        int lasts = 0;
        for (int i = 0; i < n && i < rx_data.size(); i++) begin
            if (rx_data[i] !== ram[i]) bad++;
            if (rx_last[i]) lasts++;
        end
        check({tag, "_count"}, 32'(rx_data.size()), 32'(n));
        check({tag, "_data_bad"}, 32'(bad), 32'd0);
        check({tag, "_last_cnt"}, 32'(lasts), 32'd1);
        if (rx_data.size() == n) check({tag, "_last_pos"}, {31'd0, rx_last[n-1]}, 32'd1);
    endtask

    initial begin
        rst                 = 1'b1;
        udp_rec_data_valid  = 1'b0;
        udp_rec_data_length = '0;
        m_tready            = 1'b1;
        for (int i = 0; i < 2048; i++) ram[i] = 8'(i * 5 + 7);

        // Reset state
        tick();
        tick();
        check_zero_outputs("rst");
        rst = 1'b0;
        tick();

        // Four bytes, ready high: latency N+3 and back-to-back
        ram[0] = 8'hA0; ram[1] = 8'hA1; ram[2] = 8'hA2; ram[3] = 8'hA3;
        send(8 + 4);
        wait_done("t1_timeout", 4, 1'b0);
        check("t1_count", 32'(rx_data.size()), 32'd4);
        for (int i = 0; i < 4 && i < rx_data.size(); i++) begin
            check($sformatf("t1_data%0d", i), {24'd0, rx_data[i]}, 32'(8'hA0 + i));
            check($sformatf("t1_last%0d", i), {31'd0, rx_last[i]}, {31'd0, i == 3});
            check($sformatf("t1_cyc%0d", i), 32'(rx_cyc[i]), 32'(pulse_cyc + 3 + i));
        end
        check("t1_frame", {16'd0, frame_cnt}, stat(1));
        check("t1_busy", {31'd0, busy}, 32'd0);

        // Sixteen bytes with ready toggling
        do_reset();
        for (int i = 0; i < 16; i++) ram[i] = 8'(8'h10 + i);
        m_tready = 1'b1;
        send(8 + 16);
        wait_done("t2_timeout", 16, 1'b1);
        check("t2_count", 32'(rx_data.size()), 32'd16);
        for (int i = 0; i < 16 && i < rx_data.size(); i++) begin
            check($sformatf("t2_data%0d", i), {24'd0, rx_data[i]}, 32'(8'h10 + i));
            check($sformatf("t2_last%0d", i), {31'd0, rx_last[i]}, {31'd0, i == 15});
        end
        check("t2_frame", {16'd0, frame_cnt}, stat(1));

        // Out-of-range lengths are dropped
        do_reset();
        send(8);
        repeat (3) tick();
        send(7);
        repeat (3) tick();
        send(8 + 2049);
        repeat (10) tick();
        check("t3_tvalid_cnt", 32'(tvalid_cnt), 32'd0);
        check("t3_drop", {16'd0, drop_cnt}, stat(3));
        check("t3_busy", {31'd0, busy}, 32'd0);
        check("t3_frame", {16'd0, frame_cnt}, stat(0));

        // Pulse while busy is ignored
        do_reset();
        for (int i = 0; i < 2048; i++) ram[i] = 8'(i * 3 + 1);
        send(8 + 100);
        repeat (4) tick();
        send(8 + 3);
        wait_done("t4_timeout", 100, 1'b0);
        check_pattern("t4", 100);
        check("t4_drop", {16'd0, drop_cnt}, stat(1));
        check("t4_frame", {16'd0, frame_cnt}, stat(1));

        // Reset mid-datagram, then a fresh 3-byte datagram
        do_reset();
        send(8 + 100);
        begin
            int k = 0;
            while (rx_data.size() < 50 && k < 500) begin
                tick();
                k++;
            end
            check("t5_reach50", {31'd0, k < 500}, 32'd1);
        end
        begin
            int lasts = 0;
            foreach (rx_last[i]) if (rx_last[i]) lasts++;
            check("t5_no_early_last", 32'(lasts), 32'd0);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero_outputs("t5_rst");
        ram[0] = 8'hC0; ram[1] = 8'hC1; ram[2] = 8'hC2;
        tick();
        send(8 + 3);
        wait_done("t5_timeout", 3, 1'b0);
        check_pattern("t5", 3);
        check("t5_frame", {16'd0, frame_cnt}, stat(1));

        // Maximum payload, no address wrap
        do_reset();
        for (int i = 0; i < 2048; i++) ram[i] = 8'((i ^ (i >> 3)) & 8'hFF);
        send(8 + 2048);
        wait_done("t6_timeout", 2048, 1'b0);
        check_pattern("t6", 2048);
        check("t6_max_addr", 32'(max_addr), 32'd2047);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_frame", {16'd0, frame_cnt}, stat(1));
        check("t6_drop", {16'd0, drop_cnt}, stat(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
